io_tile_cfg_chain: RTL and testbench

Parametrised configuration-chain segment for edge I/O tiles. It replaces the bare flop-chain inside a tile's connection and switch blocks with a counted shift register, a shadow commit register, readback capture and pad-direction isolation. It sits between the `ccff_head` and `ccff_tail` of one edge tile. Its `cfg_bits` output drives that tile's routing-mux selects and I/O pad configuration.

---
 rtl/io_tile_cfg_chain.sv | 98 +++++++++
 tb/tb_io_tile_cfg_chain.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/io_tile_cfg_chain.sv
// rtl/io_tile_cfg_chain.sv - counted config chain segment with shadow commit, readback and pad isolation
module io_tile_cfg_chain #(
  parameter int NUM_IO      = 4,
  parameter int BITS_PER_IO = 2,
  parameter int ROUTE_BITS  = 24,
  localparam int LEN        = NUM_IO * BITS_PER_IO + ROUTE_BITS,
  localparam int CW         = $clog2(LEN + 2)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  input  logic              ccff_capture,
  input  logic              isol_n,
  output logic              ccff_tail,
  output logic [LEN-1:0]    cfg_bits,
  output logic              cfg_valid,
  output logic              cfg_error,
  output logic [CW-1:0]     bit_count,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir
);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL, OVERRUN} state_t;

  logic [LEN-1:0] sr_q, sr_d;
  logic [LEN-1:0] cfg_bits_q, cfg_bits_d;
  logic           cfg_valid_q, cfg_valid_d;
  logic           cfg_error_q, cfg_error_d;
  logic [CW-1:0]  bit_count_q, bit_count_d;
  state_t         state;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sr_q        <= '0;
      cfg_bits_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_error_q <= 1'b0;
      bit_count_q <= '0;
    end else begin
      sr_q        <= sr_d;
      cfg_bits_q  <= cfg_bits_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_error_q <= cfg_error_d;
      bit_count_q <= bit_count_d;
    end
  end

  // The load state is fully determined by the bit counter; no separate state register.
  always_comb begin
    state = LOADING;
    if (bit_count_q == '0)                  state = EMPTY;
    else if (bit_count_q == CW'(LEN))       state = FULL;
    else if (bit_count_q == CW'(LEN + 1))   state = OVERRUN;
  end

  always_comb begin
    sr_d        = sr_q;
    cfg_bits_d  = cfg_bits_q;
    cfg_valid_d = cfg_valid_q;
    cfg_error_d = cfg_error_q;
    bit_count_d = bit_count_q;

    if (ccff_commit && ccff_capture) begin
      cfg_error_d = 1'b1;
    end else if (ccff_commit) begin
      if (state == FULL) begin
        cfg_bits_d  = sr_q;
        cfg_valid_d = 1'b1;
        cfg_error_d = 1'b0;
        bit_count_d = '0;
      end else begin
        cfg_error_d = 1'b1;
      end
    end else if (ccff_capture) begin
      sr_d        = cfg_bits_q;
      bit_count_d = '0;
    end else if (ccff_shift_en) begin
      sr_d = {sr_q[LEN-2:0], ccff_head};
      if (state != OVERRUN) bit_count_d = bit_count_q + CW'(1);
    end
  end

  // Isolation or an unprogrammed shadow parks every pad as an input.
  always_comb begin
    gfpga_pad_io_soc_dir = '1;
    for (int k = 0; k < NUM_IO; k++) begin
      if (isol_n && cfg_valid_q) gfpga_pad_io_soc_dir[k] = cfg_bits_q[k*BITS_PER_IO];
    end
  end

  assign ccff_tail = sr_q[LEN-1];
  assign cfg_bits  = cfg_bits_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_error = cfg_error_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_io_tile_cfg_chain.sv
// tb/tb_io_tile_cfg_chain.sv - directed self-checking bench for io_tile_cfg_chain
module tb_io_tile_cfg_chain;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic        ccff_head = 1'b0;
  logic        ccff_shift_en = 1'b0;
  logic        ccff_commit = 1'b0;
  logic        ccff_capture = 1'b0;
  logic        isol_n = 1'b1;
  logic        ccff_tail;
  logic [31:0] cfg_bits;
  logic        cfg_valid;
  logic        cfg_error;
  logic [5:0]  bit_count;
  logic [3:0]  dir;

  int total = 0;
  int passes = 0;

  io_tile_cfg_chain dut (
    .prog_clk             (prog_clk),
    .prog_reset           (prog_reset),
    .ccff_head            (ccff_head),
    .ccff_shift_en        (ccff_shift_en),
    .ccff_commit          (ccff_commit),
    .ccff_capture         (ccff_capture),
    .isol_n               (isol_n),
    .ccff_tail            (ccff_tail),
    .cfg_bits             (cfg_bits),
    .cfg_valid            (cfg_valid),
    .cfg_error            (cfg_error),
    .bit_count            (bit_count),
    .gfpga_pad_io_soc_dir (dir)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic sh, input logic hd, input logic cm, input logic cp);
    ccff_shift_en = sh;
    ccff_head     = hd;
    ccff_commit   = cm;
    ccff_capture  = cp;
    @(posedge prog_clk);
    #1;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    ccff_commit   = 1'b0;
    ccff_capture  = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0);
  endtask

  logic [31:0] rd;

  initial begin
    repeat (2) @(posedge prog_clk);
    #1;
    check("rst_tail", ccff_tail, 0);
    check("rst_bits", cfg_bits, 0);
    check("rst_valid", cfg_valid, 0);
    check("rst_error", cfg_error, 0);
    check("rst_count", bit_count, 0);
    check("rst_dir", dir, 4'hF);
    prog_reset = 1'b0;

    shift_bits(32'hA5A5_0F0F, 32);
    check("full_count", bit_count, 32);
    check("full_tail_first_bit", ccff_tail, 1);
    check("pre_commit_dir", dir, 4'hF);
    step(0, 0, 1, 0);
    check("c1_bits", cfg_bits, 32'hA5A5_0F0F);
    check("c1_valid", cfg_valid, 1);
    check("c1_error", cfg_error, 0);
    check("c1_count", bit_count, 0);
    check("c1_dir", dir, 4'b0011);

    shift_bits(32'h1234_5678 >> 1, 31);
    step(0, 0, 1, 0);
    check("short_error", cfg_error, 1);
    check("short_bits", cfg_bits, 32'hA5A5_0F0F);
    check("short_valid", cfg_valid, 1);
    check("short_count", bit_count, 31);
    step(1, 1'b0, 0, 0);
    step(0, 0, 1, 0);
    check("c2_error", cfg_error, 0);
    check("c2_bits", cfg_bits, 32'h1234_5678);
    check("c2_dir", dir, 4'b1100);

    shift_bits(32'h0, 32);
    step(1, 1'b1, 0, 0);
    check("ovr_count", bit_count, 33);
    step(1, 1'b1, 0, 0);
    step(1, 1'b0, 0, 0);
    check("ovr_sat", bit_count, 33);
    step(0, 0, 1, 0);
    check("ovr_error", cfg_error, 1);
    check("ovr_bits", cfg_bits, 32'h1234_5678);
    step(0, 0, 0, 1);
    check("cap_clr_count", bit_count, 0);

    shift_bits(32'hDEAD_BEEF, 32);
    step(0, 0, 1, 0);
    check("c3_bits", cfg_bits, 32'hDEAD_BEEF);
    step(0, 0, 0, 1);
    check("rb_count", bit_count, 0);
    check("rb_valid", cfg_valid, 1);
    rd[31] = ccff_tail;
    for (int i = 30; i >= 0; i--) begin
      step(1, 1'b0, 0, 0);
      rd[i] = ccff_tail;
    end
    check("rb_stream", rd, 32'hDEAD_BEEF);

    step(0, 0, 0, 1);
    shift_bits(32'hCAFE_BA00, 32);
    step(0, 0, 1, 0);
    check("c4_bits", cfg_bits, 32'hCAFE_BA00);
    check("iso_dir_on", dir, 4'b0000);
    isol_n = 1'b0;
    #1;
    check("iso_dir_off", dir, 4'b1111);
    isol_n = 1'b1;
    #1;
    check("iso_dir_back", dir, 4'b0000);

    shift_bits(32'h1234, 16);
    step(1, 1'b1, 1, 1);
    check("both_error", cfg_error, 1);
    check("both_count", bit_count, 16);
    check("both_bits", cfg_bits, 32'hCAFE_BA00);
    shift_bits(32'h5678, 16);
    step(0, 0, 1, 0);
    check("both_sr_kept", cfg_bits, 32'h1234_5678);
    check("both_err_clr", cfg_error, 0);

    step(0, 0, 1, 0);
    check("repeat_commit_err", cfg_error, 1);

    shift_bits(32'h0001_FFFF, 17);
    check("mid_count", bit_count, 17);
    #2;
    prog_reset = 1'b1;
    #1;
    check("arst_bits", cfg_bits, 0);
    check("arst_valid", cfg_valid, 0);
    check("arst_error", cfg_error, 0);
    check("arst_count", bit_count, 0);
    check("arst_tail", ccff_tail, 0);
    check("arst_dir", dir, 4'hF);
    @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
